serial_alu_sequencer: RTL and testbench
=======================================

# serial_alu_sequencer

Control and data-marshalling stage that sits directly upstream and downstream of the bit-serial execution units (shifter, adder, logic). It accepts one 32-bit operand pair plus a function code through a valid/ready handshake and serialises both operands LSB-first onto `opA`/`opB`. It drives the shared 6-bit `bitPos` phase counter and the per-operation unit reset, then collects the unit's serial result bits into a parallel 32-bit word for writeback.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; the counter sizing below holds only for 32.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_valid`  in  1  operation request.
- `start_ready`  out  1  high only in IDLE.
- `rs1`  in  32  operand A, sampled on accept.
- `rs2`  in  32  operand B, sampled on accept.
- `func_in`  in  4  function code, sampled on accept.
- `func`  out  4  latched function code to the execution unit.
- `unit_rst`  out  1  one-cycle synchronous reset pulse to the execution unit.
- `opA`  out  1  serial operand A bit.
- `opB`  out  1  serial operand B bit.
- `bitPos`  out  6  phase counter.
- `res_bit`  in  1  serial result bit from the unit.
- `res_en`  in  1  `res_bit` is valid this cycle.
- `result`  out  32  assembled result.
- `done`  out  1  one-cycle pulse; `result` is valid.
- `overrun`  out  1  sticky error flag (see Configuration).

## Operation
- States: IDLE, PRIME, RUN, DONE.
- IDLE: `start_ready`=1. On `start_valid`: latch `rs1`, `rs2`, `func_in`; clear the capture counter; go to PRIME.
- PRIME: `unit_rst`=1 and `bitPos`=0. Go to RUN.
- RUN: `bitPos` increments each cycle, starting at 0 and wrapping 63→0.
  - `opA`=rs1[bitPos] and `opB`=rs2[bitPos] when `bitPos`<32; otherwise both are 0.
  - When `res_en`=1, capture: `result` <= {res_bit, result[31:1]} and the 6-bit capture count increments.
  - The edge that takes the 32nd capture moves the block to DONE.
- DONE: `done`=1 for one cycle, then IDLE. `bitPos` holds its last value.
- `result` holds until the next accept. It is not cleared on accept; it shifts only during RUN.
- `func` holds its latched value until the next accept.
- `res_en` is ignored outside RUN.
- `start_valid` is ignored outside IDLE; there is no queueing.
- `res_en` on the same edge that `bitPos` wraps: the capture is taken normally.

## Timing
- Reset values: state IDLE, `start_ready`=1, `unit_rst`=0, `opA`=`opB`=0, `bitPos`=0, `func`=0, `result`=0, `done`=0, `overrun`=0.
- Reset mid-operation: immediate return to IDLE with all reset values. No `done` is issued. The execution unit is re-primed on the next accept.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- Accept edge = cycle 0. PRIME is cycle 1. RUN begins in cycle 2 with `bitPos`=0.
- Minimum latency, with `res_en` high every RUN cycle: `done` in cycle 34.
- Back-to-back throughput: one operation per 35 cycles minimum, since `start_ready` rises in the cycle after DONE.

## Configuration
- `SERIAL_SEQ_OVERRUN_EN` defined:
  - If `bitPos` wraps 63→0 in RUN while fewer than 32 bits are captured, set `overrun`.
  - Then go directly to DONE with `done`=1 and `result` holding the partial value.
  - `overrun` clears only on `rst` or on the next accept.
- Macro not defined:
  - `overrun` is tied to 0.
  - RUN continues indefinitely, with `bitPos` wrapping, until 32 bits are captured.

## Test plan
- Pass-through: rs1=0xDEADBEEF, `res_bit`=`opA`, `res_en`=(bitPos<32) → `done` in cycle 34, `result`=0xDEADBEEF, `unit_rst` high only in cycle 1.
- Delayed unit: `res_en` first asserted at bitPos=32 with `res_bit`=1 for 32 cycles → `result`=0xFFFFFFFF, `done` in cycle 66, `overrun`=0.
- Handshake: `start_valid` held high with new operands during RUN → no second accept; `start_ready` returns to 1 in cycle 35; second op starts PRIME in cycle 36.
- Mid-operation reset: assert `rst` at bitPos=10 → same-cycle `bitPos`=0, `result`=0, `start_ready`=1; no `done` pulse.
- Overrun, macro defined: `res_en` high for only 20 cycles → at the 63→0 wrap, `overrun`=1 and `done`=1, with the 20 captured bits in `result`[31:12].
- Overrun, macro undefined: same stimulus, then 12 more `res_en` after the wrap → `done` after the 32nd capture, `overrun`=0.

Source files
------------

// File: rtl/serial_alu_sequencer_if.sv
// Request/response and bit-serial unit signals of serial_alu_sequencer.
// The sequencer uses the slave modport; the requester/unit side uses master.
interface serial_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic [3:0]       func_in;
  logic [3:0]       func;
  logic             unit_rst;
  logic             opA;
  logic             opB;
  logic [5:0]       bitPos;
  logic             res_bit;
  logic             res_en;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             overrun;

  modport slave (
    input  start_valid, rs1, rs2, func_in, res_bit, res_en,
    output start_ready, func, unit_rst, opA, opB, bitPos, result, done, overrun
  );

  modport master (
    output start_valid, rs1, rs2, func_in, res_bit, res_en,
    input  start_ready, func, unit_rst, opA, opB, bitPos, result, done, overrun
  );
endinterface

// File: rtl/serial_alu_sequencer.sv
// Serialises an accepted operand pair LSB-first to the bit-serial units and reassembles the result.
// Optional: define SERIAL_SEQ_OVERRUN_EN to abort with a sticky overrun flag when bitPos wraps early.
module serial_alu_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  serial_alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [3:0]       func_q;
  logic [5:0]       pos_q;
  logic [5:0]       cnt_q;
  logic             ready_q;
  logic             urst_q;
  logic             done_q;
  logic             capture;
  logic             last_capture;

  assign capture      = (state == RUN) && bus.res_en;
  assign last_capture = capture && (cnt_q == 6'd31);

`ifdef SERIAL_SEQ_OVERRUN_EN
  logic ovr_q;
`endif

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      func_q  <= '0;
      pos_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      urst_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SEQ_OVERRUN_EN
      ovr_q   <= 1'b0;
`endif
    end else begin
      urst_q <= 1'b0;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q     <= bus.rs1;
            b_q     <= bus.rs2;
            func_q  <= bus.func_in;
            cnt_q   <= '0;
            pos_q   <= '0;
            ready_q <= 1'b0;
            urst_q  <= 1'b1;
`ifdef SERIAL_SEQ_OVERRUN_EN
            ovr_q   <= 1'b0;
`endif
            state   <= PRIME;
          end
        end
        PRIME: state <= RUN;
        RUN: begin
          pos_q <= pos_q + 6'd1;
          if (capture) begin
            res_q <= {bus.res_bit, res_q[WIDTH-1:1]};
            cnt_q <= cnt_q + 6'd1;
          end
          // A capture on the wrap edge still counts; only a short count on wrap is an overrun.
          if (last_capture) begin
            done_q <= 1'b1;
            state  <= DONE;
          end
`ifdef SERIAL_SEQ_OVERRUN_EN
          else if (pos_q == 6'd63) begin
            ovr_q  <= 1'b1;
            done_q <= 1'b1;
            state  <= DONE;
          end
`endif
        end
        DONE: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start_ready = ready_q;
  assign bus.func        = func_q;
  assign bus.unit_rst    = urst_q;
  assign bus.bitPos      = pos_q;
  assign bus.result      = res_q;
  assign bus.done        = done_q;
  // Operand bits are driven only for phases 0..31 of RUN; upper phases present zeros.
  assign bus.opA = (state == RUN) && !pos_q[5] && a_q[pos_q[4:0]];
  assign bus.opB = (state == RUN) && !pos_q[5] && b_q[pos_q[4:0]];

`ifdef SERIAL_SEQ_OVERRUN_EN
  assign bus.overrun = ovr_q;
`else
  assign bus.overrun = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer: cycle numbers count from the accept edge (cycle 0).
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_serial_alu_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_alu_sequencer_if #(.WIDTH(32)) bus ();

  serial_alu_sequencer #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pat    = 32'hA5C30F96;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request at a falling edge; returns at the falling edge of cycle 1 (PRIME).
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    bus.start_valid = 1'b1;
    bus.rs1         = a;
    bus.rs2         = b;
    bus.func_in     = f;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Plays the execution unit from cycle 2 until done or the cycle budget runs out.
  // mode 0: echo opA while bitPos<32; 1: ones at bitPos>=32; 2: pat bits for 20 cycles;
  // 3: as 2 plus the remaining 12 pat bits starting right after the wrap.
  task automatic run_op(input int mode, input int budget, output int done_cyc,
                        output logic [31:0] opb_word, output int urst_bad,
                        output int ready_bad, output logic ovr);
    int k;
    done_cyc  = -1;
    opb_word  = '0;
    urst_bad  = 0;
    ready_bad = 0;
    ovr       = 1'b0;
    bus.res_en  = 1'b0;
    bus.res_bit = 1'b0;
    @(negedge clk);
    for (int c = 2; c <= budget; c++) begin
      if (bus.unit_rst !== 1'b0) urst_bad++;
      if (bus.start_ready !== 1'b0) ready_bad++;
      if (bus.done === 1'b1) begin
        done_cyc = c;
        ovr      = bus.overrun;
        break;
      end
      k = c - 2;
      case (mode)
        0: begin
          bus.res_en  = (bus.bitPos < 6'd32);
          bus.res_bit = bus.opA;
          if (bus.bitPos < 6'd32) opb_word[bus.bitPos[4:0]] = bus.opB;
        end
        1: begin
          bus.res_en  = (bus.bitPos >= 6'd32);
          bus.res_bit = 1'b1;
        end
        default: begin
          if (k < 20) begin
            bus.res_en  = 1'b1;
            bus.res_bit = pat[k];
          end else if (mode == 3 && k >= 64 && k < 76) begin
            bus.res_en  = 1'b1;
            bus.res_bit = pat[k-44];
          end else begin
            bus.res_en  = 1'b0;
            bus.res_bit = 1'b0;
          end
        end
      endcase
      @(negedge clk);
    end
    bus.res_en  = 1'b0;
    bus.res_bit = 1'b0;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.rs1         = '0;
    bus.rs2         = '0;
    bus.func_in     = '0;
    bus.res_bit     = 1'b0;
    bus.res_en      = 1'b0;
    #3;
    checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.start_ready); end
    checks++; if ({bus.unit_rst, bus.opA, bus.opB, bus.done, bus.overrun} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {bus.unit_rst, bus.opA, bus.opB, bus.done, bus.overrun}); end
    checks++; if (bus.bitPos !== 6'd0) begin errors++; $display("FAIL reset_bitpos: got %0d expected 0", bus.bitPos); end
    checks++; if (bus.result !== 32'h0 || bus.func !== 4'h0) begin errors++; $display("FAIL reset_result_func: got %h/%h expected 0/0", bus.result, bus.func); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    int dc, ub, rb;
    logic [31:0] ob;
    logic ov;
    launch(32'hDEADBEEF, 32'h12345678, 4'h3);
    bus.start_valid = 1'b0;
    checks++; if (bus.unit_rst !== 1'b1) begin errors++; $display("FAIL pt_unit_rst_c1: got %b expected 1", bus.unit_rst); end
    checks++; if (bus.start_ready !== 1'b0 || bus.bitPos !== 6'd0) begin errors++; $display("FAIL pt_prime: ready %b bitPos %0d expected 0/0", bus.start_ready, bus.bitPos); end
    checks++; if (bus.func !== 4'h3) begin errors++; $display("FAIL pt_func: got %h expected 3", bus.func); end
    run_op(0, 60, dc, ob, ub, rb, ov);
    checks++; if (dc !== 34) begin errors++; $display("FAIL pt_done_cycle: got %0d expected 34", dc); end
    checks++; if (ub !== 0 || rb !== 0) begin errors++; $display("FAIL pt_unit_rst_ready_in_run: got %0d/%0d bad cycles expected 0/0", ub, rb); end
    checks++; if (ob !== 32'h12345678) begin errors++; $display("FAIL pt_opB_stream: got %h expected 12345678", ob); end
    checks++; if (bus.result !== 32'hDEADBEEF) begin errors++; $display("FAIL pt_result: got %h expected deadbeef", bus.result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL pt_overrun: got %b expected 0", ov); end
    @(negedge clk);
    checks++; if (bus.start_ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL pt_c35: ready %b done %b expected 1/0", bus.start_ready, bus.done); end
    checks++; if (bus.result !== 32'hDEADBEEF || bus.func !== 4'h3) begin errors++; $display("FAIL pt_hold: got %h/%h expected deadbeef/3", bus.result, bus.func); end
  endtask

  task automatic test_delayed_unit();
    int dc, ub, rb;
    logic [31:0] ob;
    logic ov;
    launch(32'h00000000, 32'h0, 4'h5);
    bus.start_valid = 1'b0;
    run_op(1, 100, dc, ob, ub, rb, ov);
    checks++; if (dc !== 66) begin errors++; $display("FAIL dly_done_cycle: got %0d expected 66", dc); end
    checks++; if (bus.result !== 32'hFFFFFFFF) begin errors++; $display("FAIL dly_result: got %h expected ffffffff", bus.result); end
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL dly_overrun: got %b expected 0", ov); end
    @(negedge clk);
  endtask

  task automatic test_handshake();
    int dc, ub, rb;
    logic [31:0] ob;
    logic ov;
    launch(32'h0F0F1234, 32'h11111111, 4'h7);
    bus.rs1     = 32'hCAFEF00D;
    bus.rs2     = 32'h22222222;
    bus.func_in = 4'h9;
    run_op(0, 60, dc, ob, ub, rb, ov);
    checks++; if (dc !== 34 || rb !== 0) begin errors++; $display("FAIL hs_first_op: done cycle %0d ready-high cycles %0d expected 34/0", dc, rb); end
    checks++; if (bus.result !== 32'h0F0F1234 || bus.func !== 4'h7) begin errors++; $display("FAIL hs_no_relatch: got %h/%h expected 0f0f1234/7", bus.result, bus.func); end
    @(negedge clk);
    checks++; if (bus.start_ready !== 1'b1 || bus.unit_rst !== 1'b0) begin errors++; $display("FAIL hs_c35: ready %b unit_rst %b expected 1/0", bus.start_ready, bus.unit_rst); end
    @(negedge clk);
    bus.start_valid = 1'b0;
    checks++; if (bus.unit_rst !== 1'b1 || bus.start_ready !== 1'b0) begin errors++; $display("FAIL hs_c36_prime: unit_rst %b ready %b expected 1/0", bus.unit_rst, bus.start_ready); end
    checks++; if (bus.func !== 4'h9) begin errors++; $display("FAIL hs_c36_func: got %h expected 9", bus.func); end
    run_op(0, 60, dc, ob, ub, rb, ov);
    checks++; if (dc !== 34 || bus.result !== 32'hCAFEF00D) begin errors++; $display("FAIL hs_second_op: done cycle %0d result %h expected 34/cafef00d", dc, bus.result); end
    checks++; if (ob !== 32'h22222222) begin errors++; $display("FAIL hs_second_opB: got %h expected 22222222", ob); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit found;
    int done_seen, ready_low;
    found = 1'b0;
    launch(32'h13572468, 32'h0, 4'hA);
    bus.start_valid = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.bitPos == 6'd10) begin
        found = 1'b1;
        break;
      end
      bus.res_en  = (bus.bitPos < 6'd32);
      bus.res_bit = bus.opA;
    end
    bus.res_en = 1'b0;
    checks++; if (found !== 1'b1 || bus.result === 32'h0) begin errors++; $display("FAIL mr_reach_bitpos10: found %b result %h expected 1/nonzero", found, bus.result); end
    rst = 1'b1;
    #1;
    checks++; if (bus.bitPos !== 6'd0 || bus.result !== 32'h0) begin errors++; $display("FAIL mr_clear: bitPos %0d result %h expected 0/0", bus.bitPos, bus.result); end
    checks++; if (bus.start_ready !== 1'b1 || bus.func !== 4'h0 || bus.unit_rst !== 1'b0) begin errors++; $display("FAIL mr_state: ready %b func %h unit_rst %b expected 1/0/0", bus.start_ready, bus.func, bus.unit_rst); end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    ready_low = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.done !== 1'b0) done_seen++;
      if (bus.start_ready !== 1'b1) ready_low++;
    end
    checks++; if (done_seen !== 0 || ready_low !== 0) begin errors++; $display("FAIL mr_no_done: done cycles %0d ready-low cycles %0d expected 0/0", done_seen, ready_low); end
  endtask

  task automatic test_overrun();
    int dc, ub, rb;
    logic [31:0] ob;
    logic ov;
    launch(32'h0, 32'h0, 4'h1);
    bus.start_valid = 1'b0;
`ifdef SERIAL_SEQ_OVERRUN_EN
    run_op(2, 100, dc, ob, ub, rb, ov);
    checks++; if (dc !== 66 || ov !== 1'b1) begin errors++; $display("FAIL ovr_abort: done cycle %0d overrun %b expected 66/1", dc, ov); end
    checks++; if (bus.result[31:12] !== pat[19:0]) begin errors++; $display("FAIL ovr_partial: got %h expected %h", bus.result[31:12], pat[19:0]); end
    @(negedge clk);
    checks++; if (bus.overrun !== 1'b1 || bus.start_ready !== 1'b1) begin errors++; $display("FAIL ovr_sticky: overrun %b ready %b expected 1/1", bus.overrun, bus.start_ready); end
`else
    run_op(3, 100, dc, ob, ub, rb, ov);
    checks++; if (dc !== 78 || ov !== 1'b0) begin errors++; $display("FAIL ovr_off_done: done cycle %0d overrun %b expected 78/0", dc, ov); end
    checks++; if (bus.result !== pat) begin errors++; $display("FAIL ovr_off_result: got %h expected %h", bus.result, pat); end
    @(negedge clk);
`endif
    launch(32'h55AA00FF, 32'h0, 4'h2);
    bus.start_valid = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear_on_accept: got %b expected 0", bus.overrun); end
    run_op(0, 60, dc, ob, ub, rb, ov);
    checks++; if (dc !== 34 || bus.result !== 32'h55AA00FF) begin errors++; $display("FAIL ovr_next_op: done cycle %0d result %h expected 34/55aa00ff", dc, bus.result); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int dc, ub, rb;
    logic [31:0] ob;
    logic ov;
    logic [31:0] a_vec [2];
    logic [3:0]  f_vec [2];
    a_vec[0] = 32'h80000001; f_vec[0] = 4'hC;
    a_vec[1] = 32'h7FFFFFFE; f_vec[1] = 4'h4;
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.start_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, bus.start_ready); end
      launch(a_vec[i], ~a_vec[i], f_vec[i]);
      bus.start_valid = 1'b0;
      checks++; if (bus.unit_rst !== 1'b1 || bus.func !== f_vec[i]) begin errors++; $display("FAIL b2b_prime_%0d: unit_rst %b func %h expected 1/%h", i, bus.unit_rst, bus.func, f_vec[i]); end
      run_op(0, 60, dc, ob, ub, rb, ov);
      checks++; if (dc !== 34 || bus.result !== a_vec[i]) begin errors++; $display("FAIL b2b_op_%0d: done cycle %0d result %h expected 34/%h", i, dc, bus.result, a_vec[i]); end
      checks++; if (ob !== ~a_vec[i]) begin errors++; $display("FAIL b2b_opB_%0d: got %h expected %h", i, ob, ~a_vec[i]); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_delayed_unit();
    test_handshake();
    test_mid_reset();
    test_overrun();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
